// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command path: opcodes, result-mux width,
// the divide-by-zero result pattern and the sequencer state encoding.
package alu_pkg;

  localparam int NUM_SEL = 16;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MULT = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_NOT  = 4'd9;
  localparam logic [3:0] OP_NAND = 4'd10;
  localparam logic [3:0] OP_NOR  = 4'd11;
  localparam logic [3:0] OP_LAST_LEGAL = 4'd11;

  localparam logic [31:0] DIV0_RESULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational opcode decoder: one-hot result-mux select plus an error flag
// for reserved opcodes and divide-by-zero. The select is all-zero on error.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [3:0]         op_i,
  input  logic [15:0]        b_i,
  output logic [NUM_SEL-1:0] sel_o,
  output logic               err_o
);

  assign err_o = (op_i > OP_LAST_LEGAL) || ((op_i == OP_DIV) && (b_i == 16'd0));

  always_comb begin
    // NOTE: default every always_comb output first so no path infers a latch.
    sel_o = '0;
    if (!err_o) sel_o[op_i] = 1'b1;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the combinational ALU: accepts a command, drives the
// operands and one-hot select for a settle window, then returns the result.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [15:0] alu_sel,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [3:0]  rsp_op,
  output logic        rsp_ovf,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  seq_state_e         state_q;
  logic [3:0]         cnt_q;
  logic               err_q;
  logic               cmd_ready_q;
  logic               busy_q;
  logic [15:0]        alu_a_q;
  logic [15:0]        alu_b_q;
  logic [NUM_SEL-1:0] alu_sel_q;
  logic               rsp_valid_q;
  logic [31:0]        rsp_data_q;
  logic [3:0]         rsp_op_q;
  logic               rsp_ovf_q;
  logic               rsp_err_q;

  logic [NUM_SEL-1:0] dec_sel;
  logic               dec_err;
  logic [31:0]        rsp_data_d;
  logic               rsp_ovf_d;

  alu_op_decoder u_dec (
    .op_i  (cmd_op),
    .b_i   (cmd_b),
    .sel_o (dec_sel),
    .err_o (dec_err)
  );

  // rsp_op_q already holds the in-flight opcode while in DRIVE.
  always_comb begin
    rsp_data_d = alu_result;
    if (err_q) rsp_data_d = (rsp_op_q == OP_DIV) ? DIV0_RESULT : 32'd0;
    case (rsp_op_q)
      OP_ADD:  rsp_ovf_d = alu_overflow;
      OP_SUB:  rsp_ovf_d = (alu_a_q < alu_b_q);
      default: rsp_ovf_d = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_op_q    <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            alu_a_q     <= cmd_a;
            alu_b_q     <= cmd_b;
            rsp_op_q    <= cmd_op;
            err_q       <= dec_err;
            alu_sel_q   <= dec_sel;
            cnt_q       <= SETTLE_LOAD;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == 4'd0) begin
            rsp_data_q  <= rsp_data_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp_err_q   <= err_q;
            alu_sel_q   <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_op    = rsp_op_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Sequential front-end that drives the combinational ALU operation blocks and their 16-way one-hot result mux.
- Accepts one command (4-bit opcode plus two 16-bit operands) over a valid/ready handshake.
- Decodes the opcode to the one-hot mux select and drives the operands onto the ALU.
- Holds them for a settle window, captures the 32-bit result and status, and returns a response over a second valid/ready handshake.

Parameters:
SETTLE_CYCLES, 1, edges the operands/select are held before capture (legal range 1..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; asynchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  4  opcode
cmd_a  in  16  operand A
cmd_b  in  16  operand B
alu_a  out  16  operand A driven to all ALU blocks
alu_b  out  16  operand B driven to all ALU blocks
alu_sel  out  16  one-hot result-mux select (bit n = opcode n)
alu_result  in  32  selected ALU result from the mux
alu_overflow  in  1  adder overflow (bit 16 of the sum)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts the response
rsp_data  out  32  captured result
rsp_op  out  4  opcode of this response
rsp_ovf  out  1  ADD: carry out; SUB: borrow (A<B); otherwise 0
rsp_err  out  1  divide-by-zero or reserved opcode
busy  out  1  state != IDLE

Behaviour:
- Opcode map:
  - 0 ADD, 1 SUB, 2 MULT, 3 DIV, 4 SLL, 5 SRL
  - 6 AND, 7 OR, 8 XOR, 9 NOT, 10 NAND, 11 NOR
  - 12..15 reserved
- Reset (async, rst_n low): state IDLE; cmd_ready=1. All other outputs are 0: busy, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_op, rsp_ovf, rsp_err.
- Reset mid-operation: the in-flight command and any pending response are dropped. No response is produced for them.
- FSM states: IDLE, DRIVE, RESP.
- IDLE:
  - cmd_ready=1.
  - On the edge with cmd_valid=1, register cmd_a/cmd_b into alu_a/alu_b and cmd_op into rsp_op.
  - Latch the err flag: op>=12, or op==3 with cmd_b==0.
  - Load the settle counter with SETTLE_CYCLES-1, then go to DRIVE.
- DRIVE:
  - alu_sel = one-hot(op), or 0 if err.
  - Each edge: if counter==0, capture and go to RESP; else decrement.
- Capture:
  - rsp_data: alu_result; 0xFFFF_FFFF for DIV-by-zero; 0 for reserved opcodes.
  - rsp_ovf: ADD uses alu_overflow; SUB uses (alu_a < alu_b); all others 0.
  - rsp_err: the latched err flag.
- RESP:
  - rsp_valid=1; rsp_* held stable until the edge with rsp_ready=1.
  - On that edge, rsp_valid goes to 0 and the state returns to IDLE.
- alu_sel=0 in IDLE and RESP; exactly one bit is set in DRIVE (none when err).
- alu_a/alu_b hold their last values outside DRIVE. rsp_data/rsp_op/rsp_ovf/rsp_err hold until the next capture.
- cmd_ready = (state==IDLE) only. A command offered while the sequencer is busy is not accepted and must be held by the source.
- Latency: accept at edge E0, capture at edge E(SETTLE_CYCLES), so rsp_valid is high SETTLE_CYCLES cycles after E0.
- Throughput: one command per SETTLE_CYCLES+2 cycles when rsp_ready is held at 1.
- Width rules: results are zero-extended as produced by the ALU. SUB wraps in 32 bits, e.g. 3-5 gives 0xFFFF_FFFE.
- Reserved and DIV-by-zero commands take the same DRIVE latency as legal ones.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_ADD..OP_NOR, OP_LAST_LEGAL=11
  - NUM_SEL=16
  - DIV0_RESULT=32'hFFFF_FFFF
  - FSM state encodings
- One sub-module: alu_op_decoder, combinational.
  - Input: 4-bit opcode and operand B.
  - Outputs: 16-bit one-hot select and the err flag.
  - Reused by any later block that decodes opcodes.

Test Plan:
- ADD a=50000 b=50000, SETTLE_CYCLES=1, rsp_ready=1 -> rsp_data=0x0001_86A0, rsp_ovf=1, rsp_err=0; rsp_valid 1 cycle after accept; alu_sel=0x0001 for exactly 1 cycle.
- SUB a=3 b=5 -> rsp_data=0xFFFF_FFFE, rsp_ovf=1, alu_sel=0x0002; then MULT 300*400 -> rsp_data=120000, rsp_ovf=0.
- DIV a=100 b=0 -> rsp_err=1, rsp_data=0xFFFF_FFFF, alu_sel stays 0 throughout; then DIV 100/7 -> rsp_data=14, rsp_err=0.
- Opcode 13 -> rsp_err=1, rsp_data=0, rsp_op=13, alu_sel never nonzero; latency identical to a legal opcode.
- Backpressure: rsp_ready=0 for 5 cycles with a second command waiting -> rsp_* stable, cmd_ready=0, the second command is accepted only on the cycle after the response handshake.
- rst_n pulsed low during DRIVE (SETTLE_CYCLES=4) -> all outputs go to 0 immediately, cmd_ready=1; no rsp_valid for the dropped command; the next command completes normally.
